// File: rtl/up_counter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// up_counter_if : control/status bundle for the loadable up counter
// Rev 1.0
// ---------------------------------------------------------------------------
interface up_counter_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] data;
  logic             en;
  logic [WIDTH-1:0] limit;
  logic             mode;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;
  logic             busy;

  modport master (
    output load, data, en, limit, mode,
    input  count, tc, ovf, busy
  );

  modport slave (
    input  load, data, en, limit, mode,
    output count, tc, ovf, busy
  );
endinterface
`default_nettype wire

// File: rtl/up_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// up_counter : loadable up counter, wraps or saturates at a live limit
// Rev 1.0
// ---------------------------------------------------------------------------
module up_counter #(
  parameter int WIDTH = 8
) (
  input  wire logic    clk,
  input  wire logic    rst,
  up_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    if (bus.load) begin
      count_d = bus.data;
      ovf_d   = 1'b0;
      state_d = S_COUNT;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        S_COUNT: begin
          if (bus.en) begin
            // Only an exact match is terminal; rolling past all-ones is silent.
            if (count_q == bus.limit) begin
              tc_d = 1'b1;
              if (bus.mode) begin
                state_d = S_DONE;
                busy_d  = 1'b0;
              end else begin
                count_d = '0;
                ovf_d   = 1'b1;
              end
            end else begin
              count_d = count_q + c_one;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_up_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_up_counter : directed vector bench for up_counter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_up_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  up_counter_if #(.WIDTH(8)) bus ();

  up_counter #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic       load;
    logic [7:0] data;
    logic       en;
    logic [7:0] limit;
    logic       mode;
    logic [7:0] cnt;
    logic       tc;
    logic       ovf;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic l, input logic [7:0] d,
                              input logic e, input logic [7:0] lim, input logic m,
                              input logic [7:0] c, input logic t, input logic o,
                              input logic b);
    vec_t v;
    v.rst = r; v.load = l; v.data = d; v.en = e; v.limit = lim; v.mode = m;
    v.cnt = c; v.tc = t; v.ovf = o; v.busy = b;
    return v;
  endfunction

  task automatic drive(input logic r, input logic l, input logic [7:0] d,
                       input logic e, input logic [7:0] lim, input logic m);
    @(negedge clk);
    rst       = r;
    bus.load  = l;
    bus.data  = d;
    bus.en    = e;
    bus.limit = lim;
    bus.mode  = m;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] c, input logic t,
                       input logic o, input logic b);
    checks++;
    if (bus.count !== c || bus.tc !== t || bus.ovf !== o || bus.busy !== b) begin
      failures++;
      $display("FAIL %s: got count=%0d tc=%b ovf=%b busy=%b, want count=%0d tc=%b ovf=%b busy=%b",
               name, bus.count, bus.tc, bus.ovf, bus.busy, c, t, o, b);
    end
  endtask

  initial begin
    bus.load = 1'b0; bus.data = '0; bus.en = 1'b0; bus.limit = '0; bus.mode = 1'b0;

    // reset, then enable without load stays idle
    vecs.push_back(mk(1, 0, 0,   0, 3,   0,   0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 0, 1, 3,   0,   0, 0, 0, 0));
    // wrap mode at 253
    vecs.push_back(mk(0, 1, 250, 1, 253, 0, 250, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,   1, 253, 0, 251, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,   1, 253, 0, 252, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,   1, 253, 0, 253, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,   1, 253, 0,   0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0,   1, 253, 0,   1, 0, 1, 1));
    // saturate at 5, then load from DONE
    vecs.push_back(mk(0, 1, 3,   1, 5,   1,   3, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,   1, 5,   1,   4, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,   1, 5,   1,   5, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,   1, 5,   1,   5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   1, 5,   1,   5, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,   1, 5,   1,   5, 0, 0, 0));
    vecs.push_back(mk(0, 1, 9,   0, 5,   1,   9, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,   1, 5,   1,  10, 0, 0, 1));
    // limit 0 in wrap mode: tc every enabled edge
    vecs.push_back(mk(0, 1, 0,   1, 0,   0,   0, 0, 0, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 0, 1, 0,   0,   0, 1, 1, 1));
    // loading data == limit makes the next enabled edge terminal
    vecs.push_back(mk(0, 1, 7,   0, 7,   1,   7, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,   1, 7,   1,   7, 1, 0, 0));
    // en=0 holds; mode flipped live to wrap
    vecs.push_back(mk(0, 1, 4,   0, 9,   1,   4, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 9,   1,   4, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,   1, 9,   1,   5, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,   1, 5,   0,   0, 1, 1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].load, vecs[i].data, vecs[i].en, vecs[i].limit, vecs[i].mode);
      check($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].tc, vecs[i].ovf, vecs[i].busy);
    end

    // alternating enable: tc on the 11th enabled edge
    drive(0, 1, 0, 0, 10, 0);
    check("toggle_load", 0, 0, 0, 1);
    for (int k = 1; k <= 11; k++) begin
      drive(0, 0, 0, 0, 10, 0);
      check($sformatf("toggle_hold%0d", k), 8'((k - 1) % 11), 0, 0, 1);
      drive(0, 0, 0, 1, 10, 0);
      check($sformatf("toggle_en%0d", k), 8'(k % 11), (k == 11), (k == 11), 1);
    end

    // start above limit: silent natural roll, then terminal wrap at 5
    drive(0, 1, 200, 0, 5, 0);
    check("roll_load", 200, 0, 0, 1);
    for (int k = 1; k <= 62; k++) begin
      drive(0, 0, 0, 1, 5, 0);
      if (k <= 61)
        check($sformatf("roll%0d", k), 8'((200 + k) % 256), 0, 0, 1);
      else
        check("roll_wrap", 0, 1, 1, 1);
    end

    // reset together with load mid-count aborts to IDLE
    drive(0, 1, 0, 0, 20, 0);
    for (int k = 1; k <= 7; k++) drive(0, 0, 0, 1, 20, 0);
    check("abort_pre", 7, 0, 0, 1);
    drive(1, 1, 99, 1, 20, 0);
    check("abort_rst", 0, 0, 0, 0);
    drive(0, 0, 0, 1, 20, 0);
    check("abort_idle", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
